// File: rtl/bus_slave_param.sv
// rtl/bus_slave_param.sv - serial bus slave: LSB-first address/data framing over a word memory
// Optional split-read support is compiled in when SLAVE_SPLIT_EN is defined.
module bus_slave_param #(
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 8,
    parameter int                MEM_DEPTH = 4096,
    parameter logic [DATA_W-1:0] INIT_VAL  = DATA_W'(8'hAD)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ad_sel_i,
    input  logic              b_rw_i,
    input  logic              b_bus_out_i,
    output logic              b_bus_in_o,
    output logic              b_ack_o,
    output logic              b_ready_o,
    output logic              b_sbsy_o,
    input  logic              b_split_i,
    input  logic              b_spl_resume_i,
    input  logic              s_split_i,
    output logic              s_dvalid_o,
    output logic [DATA_W-1:0] s_dout_o
);
    localparam int                MAX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int                CNT_W  = $clog2(MAX_W);
    localparam logic [CNT_W-1:0]  LAST_A = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  LAST_D = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]   DEPTH  = (ADDR_W + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_WRITE, S_ACK_W, S_SPLIT, S_READ
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                rw_q, ok_q, split_q;
    logic                b_bus_in_q, b_ack_q, b_ready_q, b_sbsy_q, s_dvalid_q;
    logic [DATA_W-1:0]   s_dout_q;

    // Memory survives reset, so it lives outside the reset domain.
    logic [DATA_W-1:0]   mem_q [MEM_DEPTH] = '{default: INIT_VAL};

    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   data_d;
    logic [DATA_W-1:0]   rd_word;
    logic                addr_ok, mem_we, split_req, resume;

    assign addr_d  = {b_bus_out_i, addr_q[ADDR_W-1:1]};
    assign data_d  = {b_bus_out_i, data_q[DATA_W-1:1]};
    assign addr_ok = {1'b0, addr_d} < DEPTH;
    assign rd_word = mem_q[addr_q];
    assign mem_we  = !rst_i && (state_q == S_WRITE) && ad_sel_i && (cnt_q == LAST_D);

`ifdef SLAVE_SPLIT_EN
    assign split_req = s_split_i;
    assign resume    = b_split_i & b_spl_resume_i;
`else
    assign split_req = 1'b0;
    assign resume    = 1'b0;
    logic unused_split;
    assign unused_split = &{1'b0, s_split_i, b_split_i, b_spl_resume_i};
`endif

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[addr_q] <= data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            ok_q       <= 1'b0;
            split_q    <= 1'b0;
            b_bus_in_q <= 1'b0;
            b_ack_q    <= 1'b0;
            b_ready_q  <= 1'b0;
            b_sbsy_q   <= 1'b0;
            s_dvalid_q <= 1'b0;
            s_dout_q   <= '0;
        end else begin
            b_bus_in_q <= 1'b0;
            b_ack_q    <= 1'b0;
            b_ready_q  <= 1'b0;
            b_sbsy_q   <= 1'b0;
            s_dvalid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ad_sel_i) begin
                        addr_q  <= addr_d;
                        cnt_q   <= CNT_W'(1);
                        state_q <= S_ADDR;
                    end else begin
                        b_ready_q <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (!ad_sel_i) begin
                        state_q   <= S_IDLE;
                        b_ready_q <= 1'b1;
                    end else begin
                        addr_q <= addr_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        // Split request is sampled with B_RW so B_SBSY can be a registered ACK_A output.
                        if (cnt_q == LAST_A) begin
                            rw_q     <= b_rw_i;
                            ok_q     <= addr_ok;
                            split_q  <= split_req;
                            b_ack_q  <= addr_ok;
                            b_sbsy_q <= addr_ok & !b_rw_i & split_req;
                            state_q  <= S_ACK_A;
                        end
                    end
                end
                S_ACK_A: begin
                    cnt_q <= '0;
                    if (!ok_q) begin
                        state_q   <= S_IDLE;
                        b_ready_q <= 1'b1;
                    end else if (rw_q) begin
                        state_q <= S_WRITE;
                    end else if (split_q) begin
                        state_q <= S_SPLIT;
                    end else begin
                        data_q     <= rd_word;
                        b_bus_in_q <= rd_word[0];
                        state_q    <= S_READ;
                    end
                end
                S_WRITE: begin
                    if (!ad_sel_i) begin
                        state_q   <= S_IDLE;
                        b_ready_q <= 1'b1;
                    end else begin
                        data_q <= data_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_D) begin
                            b_ack_q    <= 1'b1;
                            s_dvalid_q <= 1'b1;
                            s_dout_q   <= data_d;
                            state_q    <= S_ACK_W;
                        end
                    end
                end
                S_ACK_W: begin
                    state_q   <= S_IDLE;
                    b_ready_q <= 1'b1;
                end
                S_SPLIT: begin
                    if (resume) begin
                        data_q     <= rd_word;
                        b_bus_in_q <= rd_word[0];
                        cnt_q      <= '0;
                        state_q    <= S_READ;
                    end
                end
                S_READ: begin
                    if (!ad_sel_i || (cnt_q == LAST_D)) begin
                        state_q   <= S_IDLE;
                        b_ready_q <= 1'b1;
                    end else begin
                        data_q     <= data_q >> 1;
                        b_bus_in_q <= data_q[1];
                        cnt_q      <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign b_bus_in_o = b_bus_in_q;
    assign b_ack_o    = b_ack_q;
    assign b_ready_o  = b_ready_q;
    assign b_sbsy_o   = b_sbsy_q;
    assign s_dvalid_o = s_dvalid_q;
    assign s_dout_o   = s_dout_q;
endmodule

// File: tb/tb_bus_slave_param.sv
// tb/tb_bus_slave_param.sv - self-checking bench for bus_slave_param (MEM_DEPTH=4000)
module tb_bus_slave_param;
    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ad_sel, b_rw, bus_out, b_split, b_spl_resume, s_split;
    logic       bus_in, ack, ready, sbsy, dvalid;
    logic [7:0] dout;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] ref_mem [DEPTH];
    logic [7:0] last_dout;

    bus_slave_param #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .INIT_VAL(8'hAD)) dut (
        .clk_i(clk), .rst_i(rst), .ad_sel_i(ad_sel), .b_rw_i(b_rw), .b_bus_out_i(bus_out),
        .b_bus_in_o(bus_in), .b_ack_o(ack), .b_ready_o(ready), .b_sbsy_o(sbsy),
        .b_split_i(b_split), .b_spl_resume_i(b_spl_resume), .s_split_i(s_split),
        .s_dvalid_o(dvalid), .s_dout_o(dout)
    );

    typedef struct {
        bit         wr;
        logic [11:0] addr;
        logic [7:0] data;
        bit         exp_ack;
        logic [7:0] exp_rd;
    } vec_t;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_addr(input logic [11:0] a, input logic rw, input logic spl);
        for (int i = 0; i < AW; i++) begin
            ad_sel  = 1'b1;
            bus_out = a[i];
            b_rw    = rw;
            s_split = spl;
            step();
            if (i < AW - 1) chk1("addr_phase_ack", ack, 1'b0);
        end
        chk1("addr_phase_ready", ready, 1'b0);
    endtask

    task automatic do_write(input logic [11:0] a, input logic [7:0] d, input bit exp_ack);
        send_addr(a, 1'b1, 1'b0);
        chk1("wr_ack_a", ack, exp_ack);
        bus_out = 1'b0;
        step();
        if (!exp_ack) begin
            chk1("wr_bad_ready", ready, 1'b1);
            chk1("wr_bad_ack", ack, 1'b0);
            chk8("wr_bad_dout", dout, last_dout);
            ad_sel = 1'b0;
            return;
        end
        for (int i = 0; i < DW; i++) begin
            bus_out = d[i];
            step();
            if (i < DW - 1) begin
                chk1("wr_data_ack", ack, 1'b0);
                chk1("wr_data_dvalid", dvalid, 1'b0);
            end
        end
        chk1("wr_ack_w", ack, 1'b1);
        chk1("wr_dvalid", dvalid, 1'b1);
        chk8("wr_dout", dout, d);
        ref_mem[a] = d;
        last_dout  = d;
        step();
        chk1("wr_end_ready", ready, 1'b1);
        chk1("wr_end_dvalid", dvalid, 1'b0);
        chk8("wr_hold_dout", dout, last_dout);
        ad_sel = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] a, input logic spl, input bit exp_ack,
                           input logic [7:0] exp_d);
        logic [7:0] got;
        send_addr(a, 1'b0, spl);
        chk1("rd_ack_a", ack, exp_ack);
`ifdef SLAVE_SPLIT_EN
        chk1("rd_sbsy", sbsy, exp_ack & spl);
`else
        chk1("rd_sbsy", sbsy, 1'b0);
`endif
        s_split = 1'b0;
        step();
        if (!exp_ack) begin
            chk1("rd_bad_ready", ready, 1'b1);
            chk1("rd_bad_bus_in", bus_in, 1'b0);
            ad_sel = 1'b0;
            return;
        end
`ifdef SLAVE_SPLIT_EN
        if (spl) begin
            for (int i = 0; i < 5; i++) begin
                chk1("split_hold_bus", bus_in, 1'b0);
                chk1("split_hold_sbsy", sbsy, 1'b0);
                ad_sel  = 1'($urandom_range(0, 1));
                b_split = (i >= 2);
                step();
            end
            chk1("split_hold_ready", ready, 1'b0);
            b_split      = 1'b1;
            b_spl_resume = 1'b1;
            step();
            b_split      = 1'b0;
            b_spl_resume = 1'b0;
            ad_sel       = 1'b1;
        end
`endif
        got = '0;
        for (int i = 0; i < DW; i++) begin
            got[i] = bus_in;
            if (i < DW - 1) step();
        end
        chk8("rd_data", got, exp_d);
        step();
        chk1("rd_end_ready", ready, 1'b1);
        chk1("rd_end_bus_in", bus_in, 1'b0);
        ad_sel = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [12];
        logic [11:0] a;
        logic [7:0]  d;
        bit          ok;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hAD;
        last_dout = 8'h00;
        rst = 1'b1; ad_sel = 1'b0; b_rw = 1'b0; bus_out = 1'b0;
        b_split = 1'b0; b_spl_resume = 1'b0; s_split = 1'b0;

        step();
        step();
        chk1("rst_ack", ack, 1'b0);
        chk1("rst_ready", ready, 1'b0);
        chk1("rst_sbsy", sbsy, 1'b0);
        chk1("rst_dvalid", dvalid, 1'b0);
        chk1("rst_bus_in", bus_in, 1'b0);
        chk8("rst_dout", dout, 8'h00);
        rst = 1'b0;
        step();
        chk1("post_rst_ready", ready, 1'b1);

        vecs[0]  = '{1'b1, 12'h003, 8'h5A, 1'b1, 8'h00};
        vecs[1]  = '{1'b0, 12'h003, 8'h00, 1'b1, 8'h5A};
        vecs[2]  = '{1'b0, 12'h004, 8'h00, 1'b1, 8'hAD};
        vecs[3]  = '{1'b0, 12'hFA0, 8'h00, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 12'hFA0, 8'h33, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 12'hF9F, 8'h81, 1'b1, 8'h00};
        vecs[6]  = '{1'b0, 12'hF9F, 8'h00, 1'b1, 8'h81};
        vecs[7]  = '{1'b1, 12'h000, 8'hFF, 1'b1, 8'h00};
        vecs[8]  = '{1'b0, 12'h000, 8'h00, 1'b1, 8'hFF};
        vecs[9]  = '{1'b0, 12'hFFF, 8'h00, 1'b0, 8'h00};
        vecs[10] = '{1'b1, 12'h003, 8'hC3, 1'b1, 8'h00};
        vecs[11] = '{1'b0, 12'h003, 8'h00, 1'b1, 8'hC3};

        // Rows run back to back: each transaction starts in the IDLE cycle after the previous one.
        for (int v = 0; v < 12; v++) begin
            if (vecs[v].wr) do_write(vecs[v].addr, vecs[v].data, vecs[v].exp_ack);
            else            do_read(vecs[v].addr, 1'b0, vecs[v].exp_ack, vecs[v].exp_rd);
        end

        // Drop AD_SEL after 3 write data bits.
        send_addr(12'h003, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            bus_out = 1'b0;
            step();
        end
        ad_sel = 1'b0;
        step();
        chk1("abort_wr_ready", ready, 1'b1);
        chk1("abort_wr_ack", ack, 1'b0);
        chk1("abort_wr_dvalid", dvalid, 1'b0);
        chk8("abort_wr_dout", dout, last_dout);
        do_read(12'h003, 1'b0, 1'b1, ref_mem[12'h003]);

        // Drop AD_SEL part way through the address.
        for (int i = 0; i < 5; i++) begin
            ad_sel = 1'b1; bus_out = 1'b1; step();
        end
        ad_sel = 1'b0;
        step();
        chk1("abort_addr_ready", ready, 1'b1);
        chk1("abort_addr_ack", ack, 1'b0);

        // Drop AD_SEL part way through a read.
        send_addr(12'h000, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) step();
        ad_sel = 1'b0;
        step();
        chk1("abort_rd_bus_in", bus_in, 1'b0);
        chk1("abort_rd_ready", ready, 1'b1);

        // Reset in the middle of a write.
        send_addr(12'h010, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            bus_out = 1'b1; step();
        end
        rst = 1'b1;
        step();
        chk1("rstw_ack", ack, 1'b0);
        chk1("rstw_dvalid", dvalid, 1'b0);
        chk1("rstw_ready", ready, 1'b0);
        chk1("rstw_bus_in", bus_in, 1'b0);
        chk8("rstw_dout", dout, 8'h00);
        last_dout = 8'h00;
        rst    = 1'b0;
        ad_sel = 1'b0;
        step();
        chk1("rstw_release_ready", ready, 1'b1);
        do_read(12'h010, 1'b0, 1'b1, ref_mem[12'h010]);
        do_read(12'h003, 1'b0, 1'b1, ref_mem[12'h003]);

        // Split read; without SLAVE_SPLIT_EN the request is ignored and the read is immediate.
        do_read(12'h003, 1'b1, 1'b1, ref_mem[12'h003]);
        do_read(12'hF9F, 1'b1, 1'b1, ref_mem[12'hF9F]);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 0) a = 12'($urandom_range(0, 15));
            else                           a = 12'($urandom_range(0, 4095));
            d  = 8'($urandom_range(0, 255));
            ok = (int'(a) < DEPTH);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, ok);
            end else begin
                do_read(a, 1'($urandom_range(0, 1)), ok, ok ? ref_mem[a] : 8'h00);
            end
            if ($urandom_range(0, 2) == 0) begin
                step();
                chk1("gap_ready", ready, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
